// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_ACK,
    SERVICE
  } irq_state_t;

  localparam logic [31:0] MASK_DEFAULT = 32'hFFFF_FFFF;

  // Width needed to index n items; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: multi-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller with a pulse / ack / eoi
// handshake towards the cpu and automatic re-pulse when the ack does not arrive.
//
// state    | meaning
// IDLE     | nothing outstanding; waits for an enabled pending source
// PULSE    | interrupt high for this single cycle
// WAIT_ACK | request delivered; counting towards a re-pulse
// SERVICE  | cpu is in the handler; waits for eoi
module irq_controller
  import irq_pkg::*;
#(
  parameter  int NUM_SRC      = 8,
  parameter  int SYNC_STAGES  = 2,
  parameter  int RETRY_CYCLES = 64,
  localparam int ID_W         = id_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask_q,
  output logic [NUM_SRC-1:0] pending_q,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  input  logic               ack,
  input  logic               eoi,
  output logic               busy
);

  localparam int              CNT_W    = id_width(RETRY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RETRY_CYCLES - 1);

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_masked;
  logic [NUM_SRC-1:0] w_clr;
  logic [ID_W-1:0]    w_win_id;
  logic               w_req;
  logic               w_ack_take;
  irq_state_t         w_state_nxt;

  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  logic [ID_W-1:0]    r_irq_id;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_interrupt;
  irq_state_t         r_state;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_async(src_i[g]),
      .o_rise (w_rise[g])
    );
  end

  // Lowest enabled pending index wins.
  always_comb begin
    w_masked = r_pending & r_mask;
    w_req    = |w_masked;
    w_win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_masked[i]) w_win_id = ID_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_take  = 1'b0;
    case (r_state)
      IDLE:     if (w_req) w_state_nxt = PULSE;
      PULSE:    w_state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (ack) begin
          w_state_nxt = SERVICE;
          w_ack_take  = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PULSE;
        end
      end
      SERVICE:  if (eoi) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
    w_clr = w_ack_take ? (NUM_SRC'(1) << r_irq_id) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_interrupt <= 1'b0;
      r_irq_id    <= '0;
      r_cnt       <= '0;
      r_pending   <= '0;
      r_mask      <= MASK_DEFAULT[NUM_SRC-1:0];
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= (w_state_nxt == PULSE);
      if (r_state == IDLE && w_req) r_irq_id <= w_win_id;
      if (r_state == PULSE)         r_cnt <= '0;
      else if (r_state == WAIT_ACK) r_cnt <= r_cnt + 1'b1;
      // A fresh edge on the acked source beats the clear.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  assign mask_q    = r_mask;
  assign pending_q = r_pending;
  assign interrupt = r_interrupt;
  assign irq_id    = r_irq_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: vector table, directed corner sequences and
// randomized traffic compared every cycle against a request-level reference model.
module tb_irq_controller;

  localparam int S     = 2;
  localparam int RETRY = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] src_i = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic [7:0] mask_q;
  logic [7:0] pending_q;
  logic       interrupt;
  logic [2:0] irq_id;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_SRC(8), .SYNC_STAGES(S), .RETRY_CYCLES(RETRY)) dut (
    .clk(clk), .rstn(rstn), .src_i(src_i), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .mask_q(mask_q), .pending_q(pending_q), .interrupt(interrupt), .irq_id(irq_id),
    .ack(ack), .eoi(eoi), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding request, described by its id, whether the cpu
  // has acked it, and how many cycles have elapsed since it was last pulsed.
  logic [7:0] hist [0:S];
  logic [7:0] m_pend, m_mask;
  bit         m_busy, m_acked;
  int         m_id, m_since;

  task automatic model_reset();
    for (int k = 0; k <= S; k++) hist[k] = '0;
    m_pend = '0; m_mask = 8'hFF; m_busy = 0; m_acked = 0; m_id = 0; m_since = 0;
  endtask

  task automatic model_step();
    logic [7:0] rise, masked, clr;
    if (!rstn) begin
      model_reset();
      return;
    end
    rise = hist[S-1] & ~hist[S];
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = src_i;
    masked = m_pend & m_mask;
    clr = '0;
    if (!m_busy) begin
      if (masked != 0) begin
        m_busy = 1; m_acked = 0; m_since = 0;
        for (int i = 7; i >= 0; i--) if (masked[i]) m_id = i;
      end
    end else if (!m_acked) begin
      if (m_since == 0) m_since = 1;
      else if (ack) begin m_acked = 1; clr = 8'(1 << m_id); end
      else if (m_since == RETRY) m_since = 0;
      else m_since++;
    end else if (eoi) begin
      m_busy = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = mask_wdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_int",  32'(interrupt), 32'(m_busy && !m_acked && m_since == 0));
    chk("model_id",   32'(irq_id),    32'(m_id));
    chk("model_busy", 32'(busy),      32'(m_busy));
    chk("model_pend", 32'(pending_q), 32'(m_pend));
    chk("model_mask", 32'(mask_q),    32'(m_mask));
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    while (interrupt !== 1'b1 && n < max) begin
      cycle();
      n++;
    end
    checks++;
    if (interrupt !== 1'b1) begin
      errors++;
      $display("FAIL pulse_timeout: no interrupt within %0d cycles", max);
    end
  endtask

  typedef struct {
    logic [7:0] src;
    logic       mwe;
    logic [7:0] mwd;
    logic       a, e;
    logic       e_int;
    logic [2:0] e_id;
    logic       e_busy;
    logic [7:0] e_pend;
    logic [7:0] e_mask;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int n;
    bit saw_int;
    tbl[0]  = '{8'h08, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 8'hFF};
    tbl[1]  = '{8'h08, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 8'hFF};
    tbl[2]  = '{8'h08, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h08, 8'hFF};
    tbl[3]  = '{8'h08, 0, 8'h00, 0, 0, 1, 3'd3, 1, 8'h08, 8'hFF};
    tbl[4]  = '{8'h08, 0, 8'h00, 0, 0, 0, 3'd3, 1, 8'h08, 8'hFF};
    tbl[5]  = '{8'h08, 0, 8'h00, 1, 0, 0, 3'd3, 1, 8'h00, 8'hFF};
    tbl[6]  = '{8'h08, 0, 8'h00, 0, 1, 0, 3'd3, 0, 8'h00, 8'hFF};
    tbl[7]  = '{8'h08, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h00, 8'hFF};
    tbl[8]  = '{8'h09, 1, 8'hFE, 0, 0, 0, 3'd3, 0, 8'h00, 8'hFE};
    tbl[9]  = '{8'h09, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h00, 8'hFE};
    tbl[10] = '{8'h09, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h01, 8'hFE};
    tbl[11] = '{8'h09, 0, 8'h00, 0, 0, 0, 3'd3, 0, 8'h01, 8'hFE};
    tbl[12] = '{8'h09, 1, 8'hFF, 0, 0, 0, 3'd3, 0, 8'h01, 8'hFF};
    tbl[13] = '{8'h09, 0, 8'h00, 0, 0, 1, 3'd0, 1, 8'h01, 8'hFF};
    tbl[14] = '{8'h09, 0, 8'h00, 0, 0, 0, 3'd0, 1, 8'h01, 8'hFF};
    tbl[15] = '{8'h09, 0, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00, 8'hFF};
    tbl[16] = '{8'h09, 0, 8'h00, 0, 1, 0, 3'd0, 0, 8'h00, 8'hFF};
    tbl[17] = '{8'h00, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00, 8'hFF};

    model_reset();
    repeat (3) cycle();
    chk("rst_pend", 32'(pending_q), 32'h00);
    chk("rst_mask", 32'(mask_q), 32'hFF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_int",  32'(interrupt), 0);
    chk("rst_id",   32'(irq_id), 0);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      src_i = tbl[i].src; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
      ack = tbl[i].a; eoi = tbl[i].e;
      cycle();
      chk($sformatf("tbl%0d_int", i),  32'(interrupt), 32'(tbl[i].e_int));
      chk($sformatf("tbl%0d_id", i),   32'(irq_id),    32'(tbl[i].e_id));
      chk($sformatf("tbl%0d_busy", i), 32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_pend", i), 32'(pending_q), 32'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_mask", i), 32'(mask_q),    32'(tbl[i].e_mask));
    end
    mask_we = 0; ack = 0; eoi = 0;
    repeat (3) cycle();

    // Simultaneous edges on sources 5 and 1: 1 first, 5 one cycle after IDLE.
    src_i = 8'h22;
    wait_pulse(10, n);
    chk("prio_lat", 32'(n), 4);
    chk("prio_id1", 32'(irq_id), 1);
    cycle();
    ack = 1; cycle(); ack = 0;
    chk("prio_pend", 32'(pending_q), 32'h20);
    eoi = 1; cycle(); eoi = 0;
    chk("prio_idle", 32'(busy), 0);
    cycle();
    chk("prio_int5", 32'(interrupt), 1);
    chk("prio_id5",  32'(irq_id), 5);
    cycle(); ack = 1; cycle(); ack = 0; eoi = 1; cycle(); eoi = 0;
    src_i = 8'h00; repeat (3) cycle();

    // No ack: re-pulse every RETRY+1 cycles; ack after the third pulse.
    src_i = 8'h04;
    wait_pulse(10, n);
    for (int p = 2; p <= 3; p++) begin
      cycle(); n = 1;
      while (interrupt !== 1'b1 && n < 100) begin cycle(); n++; end
      chk($sformatf("retry%0d_period", p), 32'(n), RETRY + 1);
      chk($sformatf("retry%0d_id", p), 32'(irq_id), 2);
    end
    cycle(); ack = 1; cycle(); ack = 0;
    chk("retry_pend2", 32'(pending_q[2]), 0);
    chk("retry_busy",  32'(busy), 1);
    saw_int = 0;
    repeat (RETRY + 6) begin cycle(); if (interrupt) saw_int = 1; end
    chk("svc_no_repulse", 32'(saw_int), 0);
    chk("svc_busy", 32'(busy), 1);
    eoi = 1; cycle(); eoi = 0;
    src_i = 8'h00; repeat (3) cycle();

    // Re-edge on source 4 landing exactly on the ack-clear cycle.
    src_i = 8'h10;
    wait_pulse(10, n);
    src_i = 8'h00; cycle();
    src_i = 8'h10; cycle(); cycle();
    ack = 1; cycle(); ack = 0;
    chk("reedge_pend4", 32'(pending_q[4]), 1);
    chk("reedge_busy", 32'(busy), 1);
    eoi = 1; cycle(); eoi = 0;
    wait_pulse(4, n);
    chk("reedge_id4", 32'(irq_id), 4);
    cycle(); ack = 1; cycle(); ack = 0; eoi = 1; cycle(); eoi = 0;
    src_i = 8'h00; repeat (3) cycle();

    // Reset asserted while in SERVICE with another source still pending.
    src_i = 8'h41;
    wait_pulse(10, n);
    chk("rsv_id0", 32'(irq_id), 0);
    cycle(); ack = 1; cycle(); ack = 0;
    mask_we = 1; mask_wdata = 8'h0F; cycle(); mask_we = 0;
    chk("rsv_pend", 32'(pending_q), 32'h40);
    chk("rsv_busy", 32'(busy), 1);
    src_i = 8'h00;
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pend", 32'(pending_q), 0);
    chk("arst_int",  32'(interrupt), 0);
    chk("arst_mask", 32'(mask_q), 32'hFF);
    @(negedge clk);
    cycle();
    rstn = 1'b1; eoi = 1; cycle(); eoi = 0;
    chk("spur_eoi_busy", 32'(busy), 0);
    chk("spur_eoi_int",  32'(interrupt), 0);
    cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(15) == 0) src_i[b] = ~src_i[b];
      mask_we = ($urandom_range(19) == 0);
      mask_wdata = 8'($urandom | $urandom);
      if (m_busy && !m_acked && m_since > 0) ack = ($urandom_range(3) == 0);
      else ack = ($urandom_range(29) == 0);
      if (m_busy && m_acked) eoi = ($urandom_range(2) == 0);
      else eoi = ($urandom_range(29) == 0);
      cycle();
    end
    ack = 0; eoi = 0; mask_we = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller directly upstream of the cpu core; drives the core's single-bit interrupt input.
- Collects up to NUM_SRC asynchronous external interrupt sources.
- Latches rising edges as pending bits, masks them, and selects the highest-priority request.
- Delivers each request to the core as a one-cycle pulse, then tracks an ack / end-of-interrupt handshake with automatic re-pulse on timeout.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32).
- SYNC_STAGES, 2, flip-flop synchroniser depth per source (>=2).
- RETRY_CYCLES, 64, cycles to wait for ack before re-pulsing (>=2).
- Constant ID_W = $clog2(NUM_SRC), taken from the package.

Ports:
- clk  in  1  system clock, same clock as the cpu.
- rstn  in  1  asynchronous active-low reset.
- src_i  in  NUM_SRC  raw asynchronous interrupt sources, active high.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  NUM_SRC  new enable mask; 1 = enabled.
- mask_q  out  NUM_SRC  current enable mask.
- pending_q  out  NUM_SRC  current pending bits.
- interrupt  out  1  one-cycle request pulse to the cpu.
- irq_id  out  ID_W  id of the request being delivered or in service.
- ack  in  1  cpu has taken the trap; single-cycle pulse.
- eoi  in  1  cpu has finished the handler; single-cycle pulse.
- busy  out  1  a request is outstanding (between pulse and eoi).

Behaviour:
- Reset (rstn low, asynchronous):
  - Sync chains and edge registers are cleared.
  - Outputs: pending_q = 0, mask_q = all ones, interrupt = 0, irq_id = 0, busy = 0.
  - Retry counter = 0; state = IDLE.
  - Reset asserted mid-operation abandons any outstanding request immediately.
- Synchronisation and edge detection:
  - Each src_i bit passes through SYNC_STAGES flops.
  - A rising edge of the synchronised value (0->1) sets the corresponding pending bit on the next clock.
  - A source held high sets pending only once.
  - Latency from src_i edge to pending_q = SYNC_STAGES+1 cycles.
- Mask:
  - When mask_we is high, mask_q <= mask_wdata on the next clock.
  - Masking does not clear pending bits; masked sources stay pending and are not selected.
- Selection: combinational priority encode of pending_q & mask_q; the lowest index wins.
- State machine:
  - IDLE: if any pending&mask bit is set, latch the winning id into irq_id, go to PULSE.
  - PULSE: interrupt = 1 for exactly this cycle; busy = 1; retry counter cleared; go to WAIT_ACK.
  - WAIT_ACK: busy = 1; counter increments each cycle.
    - If ack: clear pending[irq_id], go to SERVICE.
    - Else if counter == RETRY_CYCLES-1: go to PULSE (re-pulse, same irq_id).
  - SERVICE: busy = 1; eoi moves the block to IDLE.
    - A new request may pulse no earlier than 1 cycle after eoi.
  - ack outside WAIT_ACK and eoi outside SERVICE are ignored.
- irq_id is held stable from IDLE exit until the return to IDLE.
  - Higher-priority arrivals do not pre-empt: no nesting.
- Simultaneous events:
  - A new edge on the same source in the same cycle as the ack-clear: set wins, and the bit stays pending.
  - Edges on other sources during WAIT_ACK/SERVICE are latched and serviced after eoi.
  - A mask write that disables irq_id while in WAIT_ACK does not cancel the request; the handshake completes normally.
- interrupt is a registered output, glitch-free, never high two consecutive cycles.

Decomposition:
- Package irq_pkg holds:
  - ID_W derivation function.
  - State enum irq_state_t {IDLE, PULSE, WAIT_ACK, SERVICE}.
  - Default mask constant.
- One sub-module, irq_sync_edge: a per-source synchroniser plus rising-edge detector, parameterised by SYNC_STAGES.
  - Instantiated NUM_SRC times via generate.

Test Plan:
- Reset then src_i[3] rising → pending_q = 0x08 after 3 cycles; interrupt pulses 1 cycle with irq_id = 3, busy = 1.
  - ack → pending_q = 0; eoi → busy = 0.
- src_i[5] and src_i[1] rise in the same cycle → first pulse irq_id = 1.
  - After ack+eoi, a second pulse arrives with irq_id = 5 one cycle after IDLE.
- src_i[2] raised, no ack given → interrupt re-pulses every 64+1 cycles with irq_id = 2.
  - ack after the third pulse → pending_q[2] clears, state SERVICE.
- mask_wdata = 0xFE, src_i[0] rises → pending_q = 0x01, no pulse.
  - mask_wdata = 0xFF → pulse irq_id = 0 within 2 cycles.
- src_i[4] re-edge timed to land on the ack cycle → pending_q[4] stays 1; after eoi a second pulse with irq_id = 4.
- rstn dropped during SERVICE → busy, pending_q, interrupt all 0 immediately; mask_q = 0xFF.
  - Spurious eoi after reset release is ignored.
